// File: rtl/usb_fs_in_rr_arb.sv
// usb_fs_in_rr_arb
//
// Round-robin arbiter between NUM_IN_EPS USB IN endpoints and the single IN
// data path of the protocol engine. A grant is registered and then locked to
// one endpoint for the whole IN transaction. The lock is dropped when the
// protocol engine pulses arb_release, when the owner drops its request, or
// when the optional MAX_HOLD timeout expires. After every release the arbiter
// spends at least one cycle in IDLE before granting again.
//
// Ports:
//   clk              system clock
//   reset            synchronous, active-high reset
//   in_ep_req        per-endpoint request (level)
//   in_ep_grant      one-hot registered grant
//   in_ep_data       packed endpoint data, endpoint i at [i*DATA_W +: DATA_W]
//   arb_in_ep_data   data of the current owner, 0 when there is no owner
//   arb_in_ep_active high while a grant is held
//   arb_in_ep_id     index of the owner, 0 when idle
//   arb_release      one-cycle transaction-end pulse from the protocol engine
//   arb_timeout      one-cycle pulse when MAX_HOLD forced the release

module usb_fs_in_rr_arb #(
    parameter  int NUM_IN_EPS = 4,
    parameter  int DATA_W     = 8,
    parameter  int MAX_HOLD   = 0,
    localparam int ID_W       = (NUM_IN_EPS > 1) ? $clog2(NUM_IN_EPS) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_IN_EPS-1:0]        in_ep_req,
    output logic [NUM_IN_EPS-1:0]        in_ep_grant,
    input  logic [NUM_IN_EPS*DATA_W-1:0] in_ep_data,
    output logic [DATA_W-1:0]            arb_in_ep_data,
    output logic                         arb_in_ep_active,
    output logic [ID_W-1:0]              arb_in_ep_id,
    input  logic                         arb_release,
    output logic                         arb_timeout
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t          state;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] next_ptr;

    logic [ID_W-1:0] hi_sel;
    logic            hi_valid;
    logic [ID_W-1:0] lo_sel;
    logic [ID_W-1:0] sel;
    logic            sel_valid;

    logic            owner_req;
    logic            hold_expire;
    logic            release_now;

    // Round-robin pick in two passes: the lowest requesting index at or
    // above ptr wins; if there is none, the lowest requesting index overall
    // (which then necessarily sits below ptr) wins, giving the wrap-around.
    // The loops run downwards so the last hit is the lowest index.
    always_comb begin
        hi_sel   = '0;
        hi_valid = 1'b0;
        lo_sel   = '0;
        for (int i = NUM_IN_EPS - 1; i >= 0; i--) begin
            if (in_ep_req[i]) begin
                lo_sel = ID_W'(i);
                if (ID_W'(i) >= ptr) begin
                    hi_sel   = ID_W'(i);
                    hi_valid = 1'b1;
                end
            end
        end
        sel       = hi_valid ? hi_sel : lo_sel;
        sel_valid = |in_ep_req;
    end

    // The grant vector is one-hot while a grant is held, so masking the
    // requests with it yields the owner's request without indexing by id.
    assign owner_req = |(in_ep_req & in_ep_grant);

    assign next_ptr = (arb_in_ep_id == ID_W'(NUM_IN_EPS - 1)) ? '0
                                                               : arb_in_ep_id + ID_W'(1);

    assign release_now = (state == GRANT) && (arb_release || !owner_req || hold_expire);

    // Owner data mux, steered by the registered grant. With no owner the
    // grant is all zero and the output falls back to 0.
    always_comb begin
        arb_in_ep_data = '0;
        for (int i = 0; i < NUM_IN_EPS; i++) begin
            if (in_ep_grant[i]) begin
                arb_in_ep_data = in_ep_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Hold counter: counts grant cycles from 0 and flags expiry on the
    // MAX_HOLD-th cycle of ownership. Absent entirely when MAX_HOLD is 0.
    if (MAX_HOLD != 0) begin : g_hold
        localparam int              CNT_W = $clog2(MAX_HOLD) + 1;
        localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_HOLD - 1);

        logic [CNT_W-1:0] hold_cnt;

        assign hold_expire = (state == GRANT) && (hold_cnt == LAST);

        always_ff @(posedge clk) begin
            if (reset) begin
                hold_cnt <= '0;
            end else if ((state != GRANT) || release_now) begin
                hold_cnt <= '0;
            end else if (hold_cnt != LAST) begin
                hold_cnt <= hold_cnt + CNT_W'(1);
            end
        end
    end else begin : g_no_hold
        assign hold_expire = 1'b0;
    end

    // Main FSM. All outputs are registered here; arb_timeout is a single
    // cycle pulse that only fires when expiry alone caused the release, since
    // an explicit release or a request drop counts as a normal release.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            ptr              <= '0;
            in_ep_grant      <= '0;
            arb_in_ep_active <= 1'b0;
            arb_in_ep_id     <= '0;
            arb_timeout      <= 1'b0;
        end else begin
            arb_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        in_ep_grant      <= NUM_IN_EPS'(1) << sel;
                        arb_in_ep_id     <= sel;
                        arb_in_ep_active <= 1'b1;
                        state            <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        in_ep_grant      <= '0;
                        arb_in_ep_active <= 1'b0;
                        arb_in_ep_id     <= '0;
                        ptr              <= next_ptr;
                        arb_timeout      <= hold_expire && !arb_release && owner_req;
                        state            <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
